// File: rtl/sum_display_pkg.sv
// Shared types and constants for the sum display driver.
// Segment patterns are {g,f,e,d,c,b,a}, active-low.
package sum_display_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } conv_state_e;

  localparam int NUM_DIGITS = 3;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] ANODES_OFF = 4'b1111;

  // Non-decimal nibbles show nothing rather than garbage.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // Double-dabble correction; input nibble is at most 9 so 4 bits suffice.
  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

endpackage

// File: rtl/sum_display_if.sv
// Start/result handshake plus display pins of the sum display driver.
// master = requester/observer, slave = the driver itself.
interface sum_display_if;
  logic        start;
  logic [7:0]  value;
  logic        busy;
  logic        done;
  logic [11:0] bcd;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  modport master (
    output start, value,
    input  busy, done, bcd, an, seg, dp
  );

  modport slave (
    input  start, value,
    output busy, done, bcd, an, seg, dp
  );
endinterface

// File: rtl/sum_display_driver_bin2bcd.sv
// Sequential 8-bit binary to 3-digit BCD converter (shift-add-3).
// One bit per cycle; bcd only changes when a conversion completes.
module bin2bcd_seq
  import sum_display_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start_i,
  input  logic [7:0]  value_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [11:0] bcd_o
);

  conv_state_e state_q, state_d;
  logic [7:0]  shreg_q, shreg_d;
  logic [11:0] scratch_q, scratch_d;
  logic [11:0] bcd_q, bcd_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [11:0] adj;
  logic [19:0] shifted;

  // Corrected scratch and the combined left shift for this cycle.
  always_comb begin
    adj = {add3(scratch_q[11:8]),
           add3(scratch_q[7:4]),
           add3(scratch_q[3:0])};
    shifted = {adj, shreg_q} << 1;
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; start is only looked at in IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_i) state_d = SHIFT;
      SHIFT:   if (cnt_q == 3'd7) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values: capture, shift, and commit on the 8th shift.
  always_comb begin
    shreg_d   = shreg_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    bcd_d     = bcd_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          shreg_d   = value_i;
          scratch_d = '0;
          cnt_d     = '0;
        end
      end
      SHIFT: begin
        scratch_d = shifted[19:8];
        shreg_d   = shifted[7:0];
        cnt_d     = cnt_q + 3'd1;
        if (cnt_q == 3'd7) bcd_d = shifted[19:8];
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg_q   <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      bcd_q     <= '0;
    end else begin
      shreg_q   <= shreg_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      bcd_q     <= bcd_d;
    end
  end

  // Handshake outputs decoded from state.
  always_comb begin
    busy_o = (state_q != IDLE);
    done_o = (state_q == DONE);
    bcd_o  = bcd_q;
  end

endmodule

// File: rtl/sum_display_driver.sv
// Decimal display of the adder sum on a 4-digit common-anode display.
// Define LEADING_ZERO_BLANK_EN to blank leading zero digits.
module sum_display_driver
  import sum_display_pkg::*;
#(
  parameter int REFRESH_DIV = 100000
) (
  input logic         clk,
  input logic         reset,
  sum_display_if.slave bus
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] RC_MAX = CW'(REFRESH_DIV - 1);

  logic          busy_w;
  logic          done_w;
  logic [11:0]   bcd_w;

  logic [CW-1:0] rcnt_q, rcnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic [3:0]    digit;
  logic          off;
  logic          blank;

  bin2bcd_seq u_conv (
    .clk     (clk),
    .reset   (reset),
    .start_i (bus.start),
    .value_i (bus.value),
    .busy_o  (busy_w),
    .done_o  (done_w),
    .bcd_o   (bcd_w)
  );

  assign bus.busy = busy_w;
  assign bus.done = done_w;
  assign bus.bcd  = bcd_w;
  assign bus.an   = an_q;
  assign bus.seg  = seg_q;
  assign bus.dp   = 1'b1;

  // Refresh counter and digit index advance.
  always_comb begin
    rcnt_d = rcnt_q + CW'(1);
    idx_d  = idx_q;
    if (rcnt_q == RC_MAX) begin
      rcnt_d = '0;
      idx_d  = idx_q + 2'd1;
    end
  end

  // Digit select, anode pattern and leading-zero blanking.
  always_comb begin
    digit = bcd_w[3:0];
    an_d  = ANODES_OFF;
    off   = 1'b0;
    blank = 1'b0;
    unique case (idx_q)
      2'd0: begin
        digit = bcd_w[3:0];
        an_d  = 4'b1110;
      end
      2'd1: begin
        digit = bcd_w[7:4];
        an_d  = 4'b1101;
`ifdef LEADING_ZERO_BLANK_EN
        blank = (bcd_w[11:8] == 4'd0) && (bcd_w[7:4] == 4'd0);
`else
        blank = 1'b0;
`endif
      end
      2'd2: begin
        digit = bcd_w[11:8];
        an_d  = 4'b1011;
`ifdef LEADING_ZERO_BLANK_EN
        blank = (bcd_w[11:8] == 4'd0);
`else
        blank = 1'b0;
`endif
      end
      2'd3: begin
        an_d = ANODES_OFF;
        off  = 1'b1;
      end
      default: ;
    endcase
    seg_d = (off || blank) ? SEG_BLANK : seg_decode(digit);
  end

  // Scan state and registered display pins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rcnt_q <= '0;
      idx_q  <= '0;
      an_q   <= ANODES_OFF;
      seg_q  <= SEG_BLANK;
    end else begin
      rcnt_q <= rcnt_d;
      idx_q  <= idx_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
    end
  end

endmodule

// File: tb/tb_sum_display_driver.sv
// Scoreboard bench for sum_display_driver with a fast refresh.
// Expectations are hand-derived decimal values of each input.
module tb_sum_display_driver;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sum_display_if bus();

  sum_display_driver #(.REFRESH_DIV(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [11:0] bcd;
    int          due;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc++;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (bus.done === 1'b1) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_done: got done=1 at cycle %0d expected none",
                 cyc);
      end else begin
        e = q.pop_front();
        chk("done_bcd", 32'(bus.bcd), 32'(e.bcd));
        chk("done_cycle", cyc, e.due);
      end
    end
  end

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0: s = 7'b1000000;
      4'd1: s = 7'b1111001;
      4'd2: s = 7'b0100100;
      4'd3: s = 7'b0110000;
      4'd4: s = 7'b0011001;
      4'd5: s = 7'b0010010;
      4'd6: s = 7'b0000010;
      4'd7: s = 7'b1111000;
      4'd8: s = 7'b0000000;
      4'd9: s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  function automatic logic [6:0] exp_seg(input int idx, input logic [11:0] b);
    logic [3:0] h, t;
    h = b[11:8];
    t = b[7:4];
    if (idx == 0) return seg_of(b[3:0]);
`ifdef LEADING_ZERO_BLANK_EN
    if (idx == 1) return (h == 0 && t == 0) ? 7'b1111111 : seg_of(t);
    return (h == 0) ? 7'b1111111 : seg_of(h);
`else
    if (idx == 1) return seg_of(t);
    return seg_of(h);
`endif
  endfunction

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic issue(input logic [7:0] v, input logic [11:0] e,
                       input bit push);
    exp_t x;
    bus.value = v;
    bus.start = 1'b1;
    if (push) begin
      x.bcd = e;
      x.due = cyc + 9;
      q.push_back(x);
    end
    step();
    bus.start = 1'b0;
  endtask

  task automatic conv(input logic [7:0] v, input logic [11:0] e);
    int hi = 0;
    issue(v, e, 1'b1);
    for (int k = 1; k <= 9; k++) begin
      if (bus.busy === 1'b1) hi++;
      step();
    end
    chk("busy_window", hi, 9);
    chk("busy_low", 32'(bus.busy), 32'd0);
    step(2);
  endtask

  task automatic check_scan(input logic [11:0] b);
    int n;
    logic [3:0] ea;
    n = 0;
    while (bus.an !== 4'b1111 && n < 40) begin step(); n++; end
    chk("scan_sync_off", 32'(bus.an), 32'hF);
    n = 0;
    while (bus.an !== 4'b1110 && n < 40) begin step(); n++; end
    chk("scan_sync_on", 32'(bus.an), 32'hE);
    for (int s = 0; s < 16; s++) begin
      case (s / 4)
        0: ea = 4'b1110;
        1: ea = 4'b1101;
        2: ea = 4'b1011;
        default: ea = 4'b1111;
      endcase
      chk("scan_an", 32'(bus.an), 32'(ea));
      if (s / 4 < 3)
        chk("scan_seg", 32'(bus.seg), 32'(exp_seg(s / 4, b)));
      step();
    end
  endtask

  initial begin
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.value = 8'h00;
    step(2);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_bcd", 32'(bus.bcd), 32'h000);
    chk("rst_an", 32'(bus.an), 32'hF);
    chk("rst_seg", 32'(bus.seg), 32'h7F);
    chk("rst_dp", 32'(bus.dp), 32'd1);
    reset = 1'b0;
    step();
    chk("first_an", 32'(bus.an), 32'hE);
    chk("first_seg", 32'(bus.seg), 32'(7'b1000000));

    conv(8'hFE, 12'h254);
    check_scan(12'h254);
    conv(8'h00, 12'h000);
    conv(8'hFF, 12'h255);
    conv(8'h07, 12'h007);
    check_scan(12'h007);

    // Starts during SHIFT and DONE must be dropped.
    issue(8'h80, 12'h128, 1'b1);
    step(2);
    bus.value = 8'h01;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step(5);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step(4);
    chk("repulse_bcd", 32'(bus.bcd), 32'h128);
    chk("repulse_idle", 32'(bus.busy), 32'd0);

    // Reset during conversion aborts without a done pulse.
    issue(8'hC8, 12'h000, 1'b0);
    step(3);
    reset = 1'b1;
    #1;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_bcd", 32'(bus.bcd), 32'h000);
    chk("abort_an", 32'(bus.an), 32'hF);
    step(2);
    reset = 1'b0;
    step(12);

    conv(8'hC8, 12'h200);
    check_scan(12'h200);
    step(12);
    chk("pending", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
